// File: rtl/id_stage_pipe.sv
// Registered MIPS decode stage: decode, EX/MEM forwarding, load-use and mul/div hazards, ID branches.
// Optional `ID_MULDIV_EN: decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO and adds the md_cnt busy counter.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  rdata1_i,
  input  logic [DATA_W-1:0]  rdata2_i,
  input  logic               ex_we_i,
  input  logic [RADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic               ex_stall_i,
  input  logic               flush_i,
  output logic               re1_o,
  output logic               re2_o,
  output logic [RADDR_W-1:0] raddr1_o,
  output logic [RADDR_W-1:0] raddr2_o,
  output logic               stallreq_o,
  output logic               br_taken_o,
  output logic [DATA_W-1:0]  br_target_o,
  output logic               ex_valid_o,
  output logic [7:0]         aluop_o,
  output logic [2:0]         alusel_o,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic               we_o,
  output logic [DATA_W-1:0]  pc_o,
  output logic               illegal_o
);
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3,
                         SEL_ARITH = 3'd4, SEL_MUL = 3'd5, SEL_JUMP = 3'd6, SEL_LDST = 3'd7;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [3:0] MD_LAT = 4'(MULDIV_LAT);

  typedef enum logic [2:0] {OP1_RS, OP1_SHAMT, OP1_PC8, OP1_EA, OP1_ZERO} op1_sel_e;
  typedef enum logic [1:0] {OP2_RT, OP2_IMM, OP2_ZERO} op2_sel_e;

  function automatic logic [DATA_W-1:0] fwd(
    input logic re, input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] rf,
    input logic exw, input logic [RADDR_W-1:0] exa, input logic [DATA_W-1:0] exd,
    input logic mw, input logic [RADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    if (!re || a == '0)         return '0;
    else if (exw && exa == a)   return exd;
    else if (mw && ma == a)     return md;
    else                        return rf;
  endfunction

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  logic [5:0]          opcode, funct;
  logic [RADDR_W-1:0]  rs, rt, rd;
  logic [4:0]          shamt;
  logic [15:0]         imm;
  logic signed [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0]   imm_ext, fa, fb;

  assign opcode   = inst_i[31:26];
  assign rs       = inst_i[25:21];
  assign rt       = inst_i[20:16];
  assign rd       = inst_i[15:11];
  assign shamt    = inst_i[10:6];
  assign funct    = inst_i[5:0];
  assign imm      = inst_i[15:0];
  assign imm_sext = sext16(imm);

  logic [7:0] dec_aluop;
  logic [2:0] dec_alusel;
  logic       dec_we, dec_re1, dec_re2, dec_ill, br_eq, br_ne, is_j, is_jr;
  logic [RADDR_W-1:0] dec_waddr;
  op1_sel_e   op1_sel;
  op2_sel_e   op2_sel;
`ifdef ID_MULDIV_EN
  logic       md_op, md_rd;
`endif

  always_comb begin
    dec_aluop  = OP_NOP;
    dec_alusel = SEL_NOP;
    dec_we     = 1'b0;
    dec_waddr  = rd;
    dec_re1    = 1'b0;
    dec_re2    = 1'b0;
    dec_ill    = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    op1_sel    = OP1_RS;
    op2_sel    = OP2_ZERO;
`ifdef ID_MULDIV_EN
    md_op      = 1'b0;
    md_rd      = 1'b0;
`endif
    case (opcode)
      6'h00: begin
        dec_aluop = {2'b01, funct};
        case (funct)
          6'h00, 6'h02, 6'h03: begin
            dec_re2 = 1'b1; dec_we = 1'b1; dec_alusel = SEL_SHIFT;
            op1_sel = OP1_SHAMT; op2_sel = OP2_RT;
          end
          6'h04, 6'h06, 6'h07: begin
            dec_re1 = 1'b1; dec_re2 = 1'b1; dec_we = 1'b1; dec_alusel = SEL_SHIFT;
            op2_sel = OP2_RT;
          end
          6'h08: begin
            dec_re1 = 1'b1; is_jr = 1'b1; dec_alusel = SEL_JUMP;
          end
`ifdef ID_MULDIV_EN
          6'h10, 6'h12: begin
            dec_we = 1'b1; md_rd = 1'b1; dec_alusel = SEL_MOVE;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            dec_re1 = 1'b1; dec_re2 = 1'b1; md_op = 1'b1; dec_alusel = SEL_MUL;
            op2_sel = OP2_RT;
          end
`endif
          6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B: begin
            dec_re1 = 1'b1; dec_re2 = 1'b1; dec_we = 1'b1; dec_alusel = SEL_ARITH;
            op2_sel = OP2_RT;
          end
          6'h24, 6'h25, 6'h26, 6'h27: begin
            dec_re1 = 1'b1; dec_re2 = 1'b1; dec_we = 1'b1; dec_alusel = SEL_LOGIC;
            op2_sel = OP2_RT;
          end
          default: begin
            dec_ill = 1'b1; dec_aluop = OP_NOP;
          end
        endcase
      end
      6'h02: begin
        is_j = 1'b1; dec_aluop = {2'b10, opcode}; dec_alusel = SEL_JUMP;
      end
      6'h03: begin
        is_j = 1'b1; dec_we = 1'b1; dec_waddr = RADDR_W'(31); op1_sel = OP1_PC8;
        dec_aluop = {2'b10, opcode}; dec_alusel = SEL_JUMP;
      end
      6'h04, 6'h05: begin
        dec_re1 = 1'b1; dec_re2 = 1'b1; br_eq = (opcode == 6'h04); br_ne = (opcode == 6'h05);
        op2_sel = OP2_RT; dec_aluop = {2'b10, opcode}; dec_alusel = SEL_JUMP;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        dec_re1 = 1'b1; dec_we = 1'b1; dec_waddr = rt; op2_sel = OP2_IMM;
        dec_aluop  = {2'b10, opcode};
        dec_alusel = (opcode >= 6'h0C) ? SEL_LOGIC : SEL_ARITH;
      end
      6'h0F: begin
        // LUI executes as 0 | (imm << 16)
        dec_we = 1'b1; dec_waddr = rt; op1_sel = OP1_ZERO; op2_sel = OP2_IMM;
        dec_aluop = {2'b01, 6'h25}; dec_alusel = SEL_LOGIC;
      end
      6'h23, 6'h2B: begin
        // Effective address is formed here so op2 is free to carry SW store data
        dec_re1 = 1'b1; dec_re2 = (opcode == 6'h2B); dec_we = (opcode == 6'h23);
        dec_waddr = rt; op1_sel = OP1_EA; op2_sel = (opcode == 6'h2B) ? OP2_RT : OP2_ZERO;
        dec_aluop = {2'b10, opcode}; dec_alusel = SEL_LDST;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = {{(DATA_W-16){1'b0}}, imm};
      6'h0F:               imm_ext = {imm, {(DATA_W-16){1'b0}}};
      default:             imm_ext = imm_sext;
    endcase
  end

  assign fa = fwd(dec_re1, rs, rdata1_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                  mem_we_i, mem_waddr_i, mem_wdata_i);
  assign fb = fwd(dec_re2, rt, rdata2_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                  mem_we_i, mem_waddr_i, mem_wdata_i);

  assign re1_o    = dec_re1;
  assign re2_o    = dec_re2;
  assign raddr1_o = rs;
  assign raddr2_o = rt;

  logic load_use, md_hazard;
  assign load_use = in_valid_i & ex_is_load_i & ex_we_i & (ex_waddr_i != '0) &
                    ((dec_re1 & (ex_waddr_i == rs)) | (dec_re2 & (ex_waddr_i == rt)));

`ifdef ID_MULDIV_EN
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_issue;
  assign md_hazard = in_valid_i & (md_cnt_q != '0) & (md_op | md_rd);
  assign md_issue  = in_valid_i & md_op & ~stallreq_o & ~flush_i & ~ex_stall_i;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue)                              md_cnt_d = MD_LAT;
    else if (md_cnt_q != '0 && !ex_stall_i)    md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) md_cnt_q <= '0;
    else     md_cnt_q <= md_cnt_d;
  end
`else
  logic unused_md;
  assign unused_md = ^MD_LAT;
  assign md_hazard = 1'b0;
`endif

  assign stallreq_o = load_use | md_hazard;

  logic br_cond;
  logic [DATA_W-1:0] br_off;
  assign br_off      = imm_sext <<< 2;
  assign br_cond     = (br_eq & (fa == fb)) | (br_ne & (fa != fb)) | is_j | is_jr;
  assign br_taken_o  = in_valid_i & ~stallreq_o & br_cond;
  assign br_target_o = is_jr ? fa :
                       is_j  ? {pc_i[DATA_W-1:28], inst_i[25:0], 2'b00} :
                               pc_i + DATA_W'(4) + br_off;

  logic [DATA_W-1:0] op1_dec, op2_dec;
  always_comb begin
    case (op1_sel)
      OP1_SHAMT: op1_dec = {{(DATA_W-5){1'b0}}, shamt};
      OP1_PC8:   op1_dec = pc_i + DATA_W'(8);
      OP1_EA:    op1_dec = fa + imm_sext;
      OP1_ZERO:  op1_dec = '0;
      default:   op1_dec = fa;
    endcase
    case (op2_sel)
      OP2_RT:  op2_dec = fb;
      OP2_IMM: op2_dec = imm_ext;
      default: op2_dec = '0;
    endcase
  end

  // ---- ID/EX pipeline register ----
  logic               ex_valid_q, ex_valid_d, we_q, we_d, illegal_q, illegal_d;
  logic [7:0]         aluop_q, aluop_d;
  logic [2:0]         alusel_q, alusel_d;
  logic [DATA_W-1:0]  op1_q, op1_d, op2_q, op2_d, pc_q, pc_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;

  always_comb begin
    ex_valid_d = ex_valid_q; we_d = we_q; illegal_d = illegal_q;
    aluop_d = aluop_q; alusel_d = alusel_q; op1_d = op1_q; op2_d = op2_q;
    pc_d = pc_q; waddr_d = waddr_q;
    if (flush_i || (!ex_stall_i && (stallreq_o || !in_valid_i))) begin
      ex_valid_d = 1'b0; we_d = 1'b0; illegal_d = 1'b0; aluop_d = OP_NOP;
      alusel_d = SEL_NOP; op1_d = '0; op2_d = '0; pc_d = '0; waddr_d = '0;
    end else if (!ex_stall_i) begin
      ex_valid_d = 1'b1; we_d = dec_we; illegal_d = dec_ill; aluop_d = dec_aluop;
      alusel_d = dec_alusel; op1_d = op1_dec; op2_d = op2_dec; pc_d = pc_i; waddr_d = dec_waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0; we_q <= 1'b0; illegal_q <= 1'b0; aluop_q <= OP_NOP;
      alusel_q <= SEL_NOP; op1_q <= '0; op2_q <= '0; pc_q <= '0; waddr_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d; we_q <= we_d; illegal_q <= illegal_d; aluop_q <= aluop_d;
      alusel_q <= alusel_d; op1_q <= op1_d; op2_q <= op2_d; pc_q <= pc_d; waddr_q <= waddr_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign we_o       = we_q;
  assign illegal_o  = illegal_q;
  assign aluop_o    = aluop_q;
  assign alusel_o   = alusel_q;
  assign op1_o      = op1_q;
  assign op2_o      = op2_q;
  assign pc_o       = pc_q;
  assign waddr_o    = waddr_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed scoreboard bench for id_stage_pipe; mul/div timing is exercised when ID_MULDIV_EN is set.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid_i, ex_we_i, ex_is_load_i, mem_we_i, ex_stall_i, flush_i;
  logic [31:0] pc_i, inst_i, rdata1_i, rdata2_i, ex_wdata_i, mem_wdata_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i;
  logic        re1_o, re2_o, stallreq_o, br_taken_o, ex_valid_o, we_o, illegal_o;
  logic [4:0]  raddr1_o, raddr2_o, waddr_o;
  logic [31:0] br_target_o, op1_o, op2_o, pc_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;

  id_stage_pipe #(.DATA_W(32), .RADDR_W(5), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i), .mem_we_i(mem_we_i),
    .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .ex_stall_i(ex_stall_i),
    .flush_i(flush_i), .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
    .stallreq_o(stallreq_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o),
    .ex_valid_o(ex_valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .op1_o(op1_o),
    .op2_o(op2_o), .waddr_o(waddr_o), .we_o(we_o), .pc_o(pc_o), .illegal_o(illegal_o));

  always #5 clk = ~clk;

  typedef struct {
    logic        vld, we, ill, chk, nop;
    logic [4:0]  waddr;
    logic [31:0] op1, op2;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t bubble;
  int   checks = 0;
  int   errors = 0;
  int   n;

  function automatic exp_t mk(input logic vld, input logic we, input logic [4:0] waddr,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic ill, input logic chk, input logic nop);
    exp_t e;
    e.vld = vld; e.we = we; e.waddr = waddr; e.op1 = op1; e.op2 = op2;
    e.ill = ill; e.chk = chk; e.nop = nop;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: queue what ID/EX must hold after the edge, then compare it against the DUT.
  task automatic cycle(input string tag, input exp_t e);
    exp_t g;
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    cmp({tag, ".valid"}, 32'(ex_valid_o), 32'(g.vld));
    cmp({tag, ".we"}, 32'(we_o), 32'(g.we));
    cmp({tag, ".illegal"}, 32'(illegal_o), 32'(g.ill));
    if (g.nop) cmp({tag, ".nop"}, {21'd0, aluop_o, alusel_o}, 32'd0);
    if (g.chk) begin
      cmp({tag, ".waddr"}, 32'(waddr_o), 32'(g.waddr));
      cmp({tag, ".op1"}, op1_o, g.op1);
      cmp({tag, ".op2"}, op2_o, g.op2);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bubble = mk(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 1);
    rst = 1'b1; in_valid_i = 1'b1; pc_i = '0; inst_i = $urandom;
    rdata1_i = '0; rdata2_i = '0; ex_we_i = 0; ex_waddr_i = '0; ex_wdata_i = '0;
    ex_is_load_i = 0; mem_we_i = 0; mem_waddr_i = '0; mem_wdata_i = '0;
    ex_stall_i = 0; flush_i = 0;

    for (int i = 0; i < 2; i++) begin
      inst_i = $urandom; settle();
      cmp("reset.stallreq", 32'(stallreq_o), 32'd0);
      cycle("reset", bubble);
    end
    rst = 1'b0;

    // addi $1,$0,5 then add $2,$1,$1 forwarded from EX
    inst_i = i_ins(6'h08, 5'd0, 5'd1, 16'd5); rdata1_i = 32'h99; settle();
    cmp("addi.stallreq", 32'(stallreq_o), 32'd0);
    cmp("addi.raddr1", 32'(raddr1_o), 32'd0);
    cycle("addi", mk(1, 1, 5'd1, 32'd0, 32'd5, 0, 1, 0));
    inst_i = r_ins(5'd1, 5'd1, 5'd2, 5'd0, 6'h20); rdata1_i = 32'h77; rdata2_i = 32'h77;
    ex_we_i = 1; ex_waddr_i = 5'd1; ex_wdata_i = 32'd5; settle();
    cmp("add_fwd.stallreq", 32'(stallreq_o), 32'd0);
    cycle("add_fwd", mk(1, 1, 5'd2, 32'd5, 32'd5, 0, 1, 0));

    // load-use: lw $3 in EX, or $4,$3,$0 in ID
    inst_i = r_ins(5'd3, 5'd0, 5'd4, 5'd0, 6'h25); rdata1_i = '0; rdata2_i = '0;
    ex_is_load_i = 1; ex_we_i = 1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hBAD; settle();
    cmp("lu.stallreq", 32'(stallreq_o), 32'd1);
    cycle("lu.bubble", bubble);
    ex_is_load_i = 0; ex_we_i = 0; mem_we_i = 1; mem_waddr_i = 5'd3; mem_wdata_i = 32'h12345678;
    settle();
    cmp("lu.release", 32'(stallreq_o), 32'd0);
    cycle("lu.or", mk(1, 1, 5'd4, 32'h12345678, 32'd0, 0, 1, 0));

    // EX beats MEM on $6; MEM supplies $7; then plain regfile
    inst_i = r_ins(5'd6, 5'd7, 5'd5, 5'd0, 6'h20); rdata1_i = 32'h11; rdata2_i = 32'h22;
    ex_we_i = 1; ex_waddr_i = 5'd6; ex_wdata_i = 32'hAAAA;
    mem_we_i = 1; mem_waddr_i = 5'd6; mem_wdata_i = 32'hBBBB; settle();
    cycle("prio_ex", mk(1, 1, 5'd5, 32'hAAAA, 32'h22, 0, 1, 0));
    mem_waddr_i = 5'd7;
    cycle("fwd_mem", mk(1, 1, 5'd5, 32'hAAAA, 32'hBBBB, 0, 1, 0));
    ex_we_i = 0; mem_we_i = 0;
    cycle("regfile", mk(1, 1, 5'd5, 32'h11, 32'h22, 0, 1, 0));

    // immediates and shamt
    inst_i = r_ins(5'd0, 5'd2, 5'd9, 5'd3, 6'h00); rdata2_i = 32'hF0;
    cycle("sll", mk(1, 1, 5'd9, 32'd3, 32'hF0, 0, 1, 0));
    inst_i = i_ins(6'h0F, 5'd0, 5'd10, 16'h1234);
    cycle("lui", mk(1, 1, 5'd10, 32'd0, 32'h12340000, 0, 1, 0));
    inst_i = i_ins(6'h0C, 5'd0, 5'd11, 16'h8000);
    cycle("andi_zext", mk(1, 1, 5'd11, 32'd0, 32'h00008000, 0, 1, 0));
    inst_i = i_ins(6'h08, 5'd0, 5'd11, 16'h8000);
    cycle("addi_sext", mk(1, 1, 5'd11, 32'd0, 32'hFFFF8000, 0, 1, 0));

    // branches and jumps resolved in ID
    pc_i = 32'h100; inst_i = i_ins(6'h04, 5'd1, 5'd1, 16'd4); rdata1_i = 32'd7; rdata2_i = 32'd7;
    settle();
    cmp("beq.taken", 32'(br_taken_o), 32'd1);
    cmp("beq.target", br_target_o, 32'h114);
    cycle("beq", mk(1, 0, 5'd1, 32'd7, 32'd7, 0, 0, 0));
    inst_i = i_ins(6'h05, 5'd1, 5'd1, 16'd4); settle();
    cmp("bne.taken", 32'(br_taken_o), 32'd0);
    cycle("bne", mk(1, 0, 5'd1, 32'd7, 32'd7, 0, 0, 0));
    pc_i = 32'h30000100; inst_i = {6'h02, 26'h123}; settle();
    cmp("j.taken", 32'(br_taken_o), 32'd1);
    cmp("j.target", br_target_o, 32'h3000048C);
    cycle("j", mk(1, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0));
    pc_i = 32'h200; inst_i = {6'h03, 26'h80}; settle();
    cmp("jal.target", br_target_o, 32'h200);
    cycle("jal", mk(1, 1, 5'd31, 32'h208, 32'd0, 0, 1, 0));
    inst_i = r_ins(5'd5, 5'd0, 5'd0, 5'd0, 6'h08); rdata1_i = 32'hABC0; settle();
    cmp("jr.taken", 32'(br_taken_o), 32'd1);
    cmp("jr.target", br_target_o, 32'hABC0);
    cycle("jr", mk(1, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0));

    // branch waits on load-use and does not redirect meanwhile
    pc_i = 32'h100; inst_i = i_ins(6'h04, 5'd1, 5'd2, 16'd4); rdata1_i = 32'd5; rdata2_i = 32'd6;
    ex_is_load_i = 1; ex_we_i = 1; ex_waddr_i = 5'd1; settle();
    cmp("br_lu.stallreq", 32'(stallreq_o), 32'd1);
    cmp("br_lu.taken", 32'(br_taken_o), 32'd0);
    cycle("br_lu", bubble);
    ex_is_load_i = 0; ex_we_i = 0; settle();
    cmp("br_lu.ntaken", 32'(br_taken_o), 32'd0);
    cycle("br_lu.go", mk(1, 0, 5'd0, 32'd5, 32'd6, 0, 0, 0));

    // $0 never forwards; undefined opcode traps
    inst_i = r_ins(5'd0, 5'd0, 5'd6, 5'd0, 6'h20); rdata1_i = 32'h55; rdata2_i = 32'h55;
    ex_we_i = 1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hDEAD;
    cycle("zero_reg", mk(1, 1, 5'd6, 32'd0, 32'd0, 0, 1, 0));
    ex_we_i = 0;
    inst_i = {6'h3F, 26'h0};
    cycle("illegal", mk(1, 0, 5'd0, 32'd0, 32'd0, 1, 0, 1));

    // flush, hold, flush-over-stall, invalid input
    inst_i = i_ins(6'h08, 5'd0, 5'd1, 16'd5); flush_i = 1;
    cycle("flush", bubble);
    flush_i = 0; inst_i = i_ins(6'h08, 5'd0, 5'd8, 16'd9);
    cycle("pre_hold", mk(1, 1, 5'd8, 32'd0, 32'd9, 0, 1, 0));
    ex_stall_i = 1; inst_i = i_ins(6'h08, 5'd0, 5'd12, 16'd3);
    cycle("hold", last);
    flush_i = 1;
    cycle("flush_over_stall", bubble);
    flush_i = 0; ex_stall_i = 0; in_valid_i = 0;
    cycle("invalid", bubble);
    in_valid_i = 1;

`ifdef ID_MULDIV_EN
    // mult then mflo: 4 stall cycles, then 6 with ex_stall held 2 cycles mid-count
    for (int r = 0; r < 2; r++) begin
      inst_i = r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h18); settle();
      cmp("mult.stallreq", 32'(stallreq_o), 32'd0);
      cycle("mult", mk(1, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0));
      inst_i = r_ins(5'd0, 5'd0, 5'd7, 5'd0, 6'h12); settle();
      n = 0;
      while (stallreq_o === 1'b1 && n < 20) begin
        ex_stall_i = (r == 1) && (n == 1 || n == 2);
        cycle("mflo.wait", bubble);
        n++;
      end
      ex_stall_i = 0; settle();
      cmp("mflo.stall_cycles", 32'(n), (r == 0) ? 32'd4 : 32'd6);
      cycle("mflo", mk(1, 1, 5'd7, 32'd0, 32'd0, 0, 1, 0));
    end
`else
    inst_i = r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h18); settle();
    cmp("mult_off.stallreq", 32'(stallreq_o), 32'd0);
    cycle("mult_off", mk(1, 0, 5'd0, 32'd0, 32'd0, 1, 0, 1));
    inst_i = r_ins(5'd0, 5'd0, 5'd7, 5'd0, 6'h12);
    cycle("mflo_off", mk(1, 0, 5'd0, 32'd0, 32'd0, 1, 0, 1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
